// File: rtl/mul_if.sv
// Handshake/operand bundle between the Execute stage and the iterative multiplier.
// The EX side drives the request (master); the multiplier answers with busy/done/result (slave).
interface mul_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            kill_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, kill_i, op_i, a_i, b_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, kill_i, op_i, a_i, b_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU) for the Execute stage.
// Works on operand magnitudes and applies the sign to the full 2*XLEN product at the end.
module mul_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  mul_if.slave bus
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PW    = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic            signA, signB, negA, negB;
  logic [XLEN-1:0] magA, magB;
  logic [PW-1:0]   partial;
  logic [PW-1:0]   product;
  logic [XLEN-1:0] resultSel;
  logic            lastIter;
  logic            busy, done;

  // MULH treats both operands as signed, MULHSU only rs1; the magnitude of the most
  // negative value fits because it is held unsigned.
  assign signA = (bus.op_i == 2'b01) || (bus.op_i == 2'b10);
  assign signB = (bus.op_i == 2'b01);
  assign negA  = signA & bus.a_i[XLEN-1];
  assign negB  = signB & bus.b_i[XLEN-1];
  assign magA  = negA ? -bus.a_i : bus.a_i;
  assign magB  = negB ? -bus.b_i : bus.b_i;

  assign partial   = mcand_q * PW'(mplier_q[BITS_PER_CYCLE-1:0]);
  assign product   = neg_q ? -acc_q : acc_q;
  assign resultSel = (op_q == 2'b00) ? product[XLEN-1:0] : product[PW-1:XLEN];
  assign lastIter  = (count_q == CNT_W'(N - 1));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    count_d  = count_q;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.kill_i) begin
          busy     = 1'b1;
          op_d     = bus.op_i;
          neg_d    = negA ^ negB;
          mcand_d  = {{XLEN{1'b0}}, magA};
          mplier_d = magB;
          acc_d    = '0;
          count_d  = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (bus.kill_i) begin
          state_d = IDLE;
        end else begin
          // Shifting the multiplicand each step equals weighting by count*BITS_PER_CYCLE.
          acc_d    = acc_q + partial;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          count_d  = count_q + CNT_W'(1);
          if (lastIter) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!bus.kill_i) begin
          done     = 1'b1;
          result_d = resultSel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      count_q  <= count_d;
    end
  end

  // The fresh word is shown during DONE and then held by result_q until the next DONE.
  assign bus.busy_o   = busy;
  assign bus.done_o   = done;
  assign bus.result_o = done ? resultSel : result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: a BPC=1 and a BPC=4 instance against a plain
// 64-bit arithmetic reference model, plus latency, kill, reset and restart scenarios.
module tb_mul_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start1 = 1'b0;
  logic            start4 = 1'b0;
  logic            kill = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;

  int vectors = 0;
  int miscompares = 0;
  logic [XLEN-1:0] lastExp1 = '0;
  logic [XLEN-1:0] lastExp4 = '0;

  logic [1:0]  dirOp  [7] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01};
  logic [31:0] dirA   [7] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE,
                              32'h80000000, 32'h80000000};
  logic [31:0] dirB   [7] = '{32'h6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3, 32'h3,
                              32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] dirExp [7] = '{32'h0000002A, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                              32'hFFFFFFFA, 32'h80000000, 32'h00000000};

  always #5 clk = ~clk;

  mul_if #(.XLEN(XLEN)) bus1();
  mul_if #(.XLEN(XLEN)) bus4();

  assign bus1.start_i = start1;
  assign bus1.kill_i  = kill;
  assign bus1.op_i    = op;
  assign bus1.a_i     = a;
  assign bus1.b_i     = b;
  assign bus4.start_i = start4;
  assign bus4.kill_i  = kill;
  assign bus4.op_i    = op;
  assign bus4.a_i     = a;
  assign bus4.b_i     = b;

  mul_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mul_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // Reference: sign/zero-extend to 64 bits and let plain integer multiply do the work.
  function automatic logic [31:0] refMul(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = (o == 2'b01 || o == 2'b10) ? longint'($signed(x)) : longint'({32'b0, x});
    sy = (o == 2'b01) ? longint'($signed(y)) : longint'({32'b0, y});
    p  = 64'(sx * sy);
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic busyOf(input int bpc);
    return (bpc == 1) ? bus1.busy_o : bus4.busy_o;
  endfunction

  function automatic logic doneOf(input int bpc);
    return (bpc == 1) ? bus1.done_o : bus4.done_o;
  endfunction

  function automatic logic [31:0] resultOf(input int bpc);
    return (bpc == 1) ? bus1.result_o : bus4.result_o;
  endfunction

  task automatic setStart(input int bpc, input logic v);
    if (bpc == 1) start1 = v;
    else start4 = v;
  endtask

  // Drives one operation from #1 after a rising edge and observes it; returns #1 after
  // the edge that follows done_o. Cycle 0 is the cycle start_i is first presented.
  task automatic exec_op(input int bpc, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit hold, output int doneCyc,
                         output int busyCnt, output int lastBusy, output bit overlap,
                         output logic [31:0] res);
    op = o; a = x; b = y;
    setStart(bpc, 1'b1);
    doneCyc = -1; busyCnt = 0; lastBusy = -1; overlap = 1'b0; res = 'x;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busyOf(bpc)) begin busyCnt++; lastBusy = c; end
      if (busyOf(bpc) && doneOf(bpc)) overlap = 1'b1;
      if (doneOf(bpc)) begin doneCyc = c; res = resultOf(bpc); break; end
      @(posedge clk); #1;
      if (!hold) setStart(bpc, 1'b0);
    end
    @(posedge clk); #1;
    if (!hold) setStart(bpc, 1'b0);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (bus1.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy1 got %b want 0", bus1.busy_o); end
    vectors++; if (bus1.done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done1 got %b want 0", bus1.done_o); end
    vectors++; if (bus1.result_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_result1 got %h want 0", bus1.result_o); end
    vectors++; if (bus4.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy4 got %b want 0", bus4.busy_o); end
    vectors++; if (bus4.done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done4 got %b want 0", bus4.done_o); end
    vectors++; if (bus4.result_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_result4 got %h want 0", bus4.result_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input int bpc);
    int n, dc, bc, lb;
    bit ov;
    logic [31:0] r;
    n = 32 / bpc;
    for (int i = 0; i < 7; i++) begin
      exec_op(bpc, dirOp[i], dirA[i], dirB[i], 1'b0, dc, bc, lb, ov, r);
      vectors++; if (dc !== n + 1) begin miscompares++; $display("[TB] FAIL dir%0d_bpc%0d_done_cycle got %0d want %0d", i, bpc, dc, n + 1); end
      vectors++; if (bc !== n + 1) begin miscompares++; $display("[TB] FAIL dir%0d_bpc%0d_busy_cycles got %0d want %0d", i, bpc, bc, n + 1); end
      vectors++; if (lb !== n) begin miscompares++; $display("[TB] FAIL dir%0d_bpc%0d_last_busy got %0d want %0d", i, bpc, lb, n); end
      vectors++; if (ov !== 1'b0) begin miscompares++; $display("[TB] FAIL dir%0d_bpc%0d_busy_done_overlap got %b want 0", i, bpc, ov); end
      vectors++; if (r !== dirExp[i]) begin miscompares++; $display("[TB] FAIL dir%0d_bpc%0d_result got %h want %h", i, bpc, r, dirExp[i]); end
      if (bpc == 1) lastExp1 = dirExp[i]; else lastExp4 = dirExp[i];
      @(negedge clk);
      vectors++; if (resultOf(bpc) !== dirExp[i] || doneOf(bpc) !== 1'b0) begin
        miscompares++; $display("[TB] FAIL dir%0d_bpc%0d_hold got result %h done %b want %h done 0", i, bpc, resultOf(bpc), doneOf(bpc), dirExp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    int dc, bc, lb;
    bit ov;
    logic [31:0] r;
    exec_op(1, 2'b00, 32'd7, 32'd6, 1'b0, dc, bc, lb, ov, r);
    vectors++; if (r !== 32'h2A) begin miscompares++; $display("[TB] FAIL arst_pre_result got %h want 2a", r); end
    op = 2'b11; a = 32'h12345678; b = 32'h9ABCDEF0; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus1.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_busy got %b want 0", bus1.busy_o); end
    vectors++; if (bus1.result_o !== 32'h0) begin miscompares++; $display("[TB] FAIL arst_result got %h want 0", bus1.result_o); end
    vectors++; if (bus1.done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_done got %b want 0", bus1.done_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    lastExp1 = '0; lastExp4 = '0;
    @(negedge clk);
    vectors++; if (bus1.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_after_busy got %b want 0", bus1.busy_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_kill_idle();
    op = 2'b00; a = 32'd9; b = 32'd9;
    start4 = 1'b1; kill = 1'b1;
    @(negedge clk);
    vectors++; if (bus4.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL kill_idle_busy got %b want 0", bus4.busy_o); end
    @(posedge clk); #1;
    start4 = 1'b0; kill = 1'b0;
    @(negedge clk);
    vectors++; if (bus4.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL kill_idle_not_started got %b want 0", bus4.busy_o); end
    vectors++; if (bus4.done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL kill_idle_done got %b want 0", bus4.done_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_kill_calc();
    int dc, bc, lb;
    bit ov;
    logic [31:0] r, e;
    op = 2'b00; a = 32'd1000; b = 32'd77; start1 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
    end
    kill = 1'b1;
    @(negedge clk);
    vectors++; if (bus1.busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL kill_c10_busy got %b want 1", bus1.busy_o); end
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    vectors++; if (bus1.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL kill_c11_busy got %b want 0", bus1.busy_o); end
    vectors++; if (bus1.done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL kill_c11_done got %b want 0", bus1.done_o); end
    vectors++; if (bus1.result_o !== lastExp1) begin miscompares++; $display("[TB] FAIL kill_c11_result got %h want %h", bus1.result_o, lastExp1); end
    @(posedge clk); #1;
    e = refMul(2'b10, 32'hFFFF0000, 32'h00012345);
    exec_op(1, 2'b10, 32'hFFFF0000, 32'h00012345, 1'b0, dc, bc, lb, ov, r);
    vectors++; if (dc !== 33) begin miscompares++; $display("[TB] FAIL kill_restart_done_cycle got %0d want 33", dc); end
    vectors++; if (r !== e) begin miscompares++; $display("[TB] FAIL kill_restart_result got %h want %h", r, e); end
    lastExp1 = e;
  endtask

  task automatic test_kill_done();
    op = 2'b00; a = 32'd123; b = 32'd456; start4 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      start4 = 1'b0;
    end
    kill = 1'b1;
    @(negedge clk);
    vectors++; if (bus4.done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL kill_done_pulse got %b want 0", bus4.done_o); end
    vectors++; if (bus4.result_o !== lastExp4) begin miscompares++; $display("[TB] FAIL kill_done_result got %h want %h", bus4.result_o, lastExp4); end
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    vectors++; if (bus4.busy_o !== 1'b0 || bus4.done_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL kill_done_after got busy %b done %b want 0 0", bus4.busy_o, bus4.done_o);
    end
    vectors++; if (bus4.result_o !== lastExp4) begin miscompares++; $display("[TB] FAIL kill_done_after_result got %h want %h", bus4.result_o, lastExp4); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_hold();
    int dc, bc, lb;
    bit ov;
    logic [31:0] r, e;
    e = refMul(2'b01, 32'h87654321, 32'h0FEDCBA9);
    exec_op(4, 2'b01, 32'h87654321, 32'h0FEDCBA9, 1'b1, dc, bc, lb, ov, r);
    start4 = 1'b0;
    vectors++; if (dc !== 9) begin miscompares++; $display("[TB] FAIL hold_done_cycle got %0d want 9", dc); end
    vectors++; if (bc !== 9 || lb !== 8) begin miscompares++; $display("[TB] FAIL hold_busy got cycles %0d last %0d want 9 8", bc, lb); end
    vectors++; if (r !== e) begin miscompares++; $display("[TB] FAIL hold_result got %h want %h", r, e); end
    lastExp4 = e;
    @(negedge clk);
    vectors++; if (bus4.busy_o !== 1'b0 || bus4.done_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL hold_no_restart got busy %b done %b want 0 0", bus4.busy_o, bus4.done_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int dc, bc, lb;
    bit ov;
    logic [31:0] r, e1, e2;
    e1 = refMul(2'b11, 32'hDEADBEEF, 32'hCAFEF00D);
    e2 = refMul(2'b00, 32'hFFFFFFF9, 32'h00000005);
    exec_op(1, 2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, dc, bc, lb, ov, r);
    vectors++; if (dc !== 33 || r !== e1) begin miscompares++; $display("[TB] FAIL b2b_first got cycle %0d result %h want 33 %h", dc, r, e1); end
    exec_op(1, 2'b00, 32'hFFFFFFF9, 32'h00000005, 1'b1, dc, bc, lb, ov, r);
    start1 = 1'b0;
    vectors++; if (dc !== 33) begin miscompares++; $display("[TB] FAIL b2b_second_done_cycle got %0d want 33", dc); end
    vectors++; if (bc !== 33) begin miscompares++; $display("[TB] FAIL b2b_second_busy_cycles got %0d want 33", bc); end
    vectors++; if (r !== e2) begin miscompares++; $display("[TB] FAIL b2b_second_result got %h want %h", r, e2); end
    lastExp1 = e2;
    @(negedge clk);
    vectors++; if (bus1.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_idle_busy got %b want 0", bus1.busy_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int dc, bc, lb, bpc;
    bit ov;
    logic [31:0] r, e, x, y;
    logic [1:0] o;
    logic [31:0] corner [4] = '{32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
    for (int i = 0; i < 24; i++) begin
      bpc = (i % 2 == 0) ? 4 : 1;
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      y = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      e = refMul(o, x, y);
      exec_op(bpc, o, x, y, 1'b0, dc, bc, lb, ov, r);
      vectors++; if (dc !== 32 / bpc + 1) begin miscompares++; $display("[TB] FAIL rnd%0d_done_cycle got %0d want %0d", i, dc, 32 / bpc + 1); end
      vectors++; if (ov !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd%0d_overlap got %b want 0", i, ov); end
      vectors++; if (r !== e) begin miscompares++; $display("[TB] FAIL rnd%0d_result op %0d a %h b %h got %h want %h", i, o, x, y, r, e); end
    end
  endtask

  initial begin
    test_reset();
    test_directed(1);
    test_directed(4);
    test_async_reset();
    test_kill_idle();
    test_kill_calc();
    test_kill_done();
    test_start_hold();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
